// File: rtl/nes_video_pkg.sv
// rtl/nes_video_pkg.sv - NTSC NES raster constants and pattern mode encodings
package nes_video_pkg;

  localparam int DOTS_NTSC       = 341;
  localparam int LINES_NTSC      = 262;
  localparam int VIS_W           = 256;
  localparam int VIS_H           = 240;
  localparam int PRERENDER_LINE  = 261;
  localparam int VBLANK_SET_LINE = 241;
  localparam int ODD_SKIP_DOT    = 339;

  typedef enum logic [1:0] {
    MODE_SOLID  = 2'd0,
    MODE_BARS   = 2'd1,
    MODE_CHECK  = 2'd2,
    MODE_SCROLL = 2'd3
  } mode_e;

endpackage

// File: rtl/nes_pattern_gen.sv
// rtl/nes_pattern_gen.sv - combinational test pattern for one raster position
module nes_pattern_gen
  import nes_video_pkg::*;
#(
  parameter int P_VIS_W = 256,
  parameter int P_VIS_H = 240
) (
  input  mode_e       i_mode,
  input  logic [7:0]  i_color,
  input  logic [8:0]  i_dot,
  input  logic [8:0]  i_line,
  input  logic [7:0]  i_frame_cnt,
  output logic [7:0]  o_pixel
);

  logic w_visible;

  assign w_visible = (i_dot < 9'(P_VIS_W)) && (i_line < 9'(P_VIS_H));

  // Select the pattern value; blanking area always reads palette index 0
  always_comb begin
    o_pixel = 8'h00;
    if (w_visible) begin
      case (i_mode)
        MODE_SOLID:  o_pixel = i_color;
        MODE_BARS:   o_pixel = {5'b0, i_dot[7:5]};
        MODE_CHECK:  o_pixel = (i_dot[3] ^ i_line[3]) ? i_color : 8'h00;
        MODE_SCROLL: o_pixel = i_dot[7:0] + i_frame_cnt;
        default:     o_pixel = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/nes_video_source.sv
// rtl/nes_video_source.sv - NES-style raster timing and pixel stream source
module nes_video_source #(
  parameter int DIV   = 4,
  parameter int DOTS  = nes_video_pkg::DOTS_NTSC,
  parameter int LINES = nes_video_pkg::LINES_NTSC,
  parameter int VIS_W = nes_video_pkg::VIS_W,
  parameter int VIS_H = nes_video_pkg::VIS_H
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        render_en,
  input  logic [1:0]  mode,
  input  logic [7:0]  solid_color,
  output logic [7:0]  pixel_out,
  output logic        pixel_ce,
  output logic        h,
  output logic        v,
  output logic        vblank,
  output logic [8:0]  dot,
  output logic [8:0]  line,
  output logic        frame_odd
);

  // Special positions follow the NTSC constants at the native size and scale
  // with the raster otherwise (pre-render is the last line, skip is two dots
  // before line end, vblank starts one line after the visible area).
  localparam int PRE_LINE = (LINES == nes_video_pkg::LINES_NTSC) ?
                            nes_video_pkg::PRERENDER_LINE : LINES - 1;
  localparam int SKIP_DOT = (DOTS == nes_video_pkg::DOTS_NTSC) ?
                            nes_video_pkg::ODD_SKIP_DOT : DOTS - 2;
  localparam int VBL_LINE = (VIS_H == nes_video_pkg::VIS_H) ?
                            nes_video_pkg::VBLANK_SET_LINE : VIS_H + 1;

  localparam logic [8:0] L_DOT_LAST = 9'(DOTS - 1);
  localparam logic [8:0] L_PRE      = 9'(PRE_LINE);
  localparam logic [8:0] L_SKIP     = 9'(SKIP_DOT);
  localparam logic [8:0] L_VBL      = 9'(VBL_LINE);
  localparam logic [7:0] L_PRESC    = 8'(DIV - 1);

  logic [7:0]           r_presc;
  logic [8:0]           r_dot, r_line;
  logic                 r_skip, r_odd;
  logic [7:0]           r_fcnt;
  nes_video_pkg::mode_e r_mode;
  logic [7:0]           r_color;
  logic [7:0]           r_pix;
  logic                 r_ce, r_h, r_v, r_vblank;

  logic                 w_tick;
  logic [8:0]           w_dot_nx, w_line_nx;
  logic                 w_frame_start, w_skip_nx, w_vblank_nx;
  nes_video_pkg::mode_e w_mode_nx;
  logic [7:0]           w_color_nx, w_fcnt_nx, w_pix_nx;

  assign w_tick = enable && (r_presc == L_PRESC);

  // Prescaler: free-runs 0..DIV-1 while enabled, frozen otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= 8'd0;
      r_ce    <= 1'b0;
    end else begin
      r_ce <= w_tick;
      if (enable) r_presc <= w_tick ? 8'd0 : r_presc + 8'd1;
    end
  end

  // Next raster position and the values that ride along with it. The skip
  // decision is taken when entering the skip dot so h can flag that dot as
  // the last of the short line.
  always_comb begin
    w_dot_nx  = r_dot + 9'd1;
    w_line_nx = r_line;
    if (r_skip || (r_dot == L_DOT_LAST)) begin
      w_dot_nx  = 9'd0;
      w_line_nx = (r_skip || (r_line == L_PRE)) ? 9'd0 : r_line + 9'd1;
    end
    w_frame_start = (w_dot_nx == 9'd0) && (w_line_nx == 9'd0);
    w_skip_nx     = (w_line_nx == L_PRE) && (w_dot_nx == L_SKIP) && r_odd && render_en;
    w_mode_nx     = w_frame_start ? nes_video_pkg::mode_e'(mode) : r_mode;
    w_color_nx    = w_frame_start ? solid_color : r_color;
    w_fcnt_nx     = w_frame_start ? r_fcnt + 8'd1 : r_fcnt;
    w_vblank_nx   = r_vblank;
    if (w_dot_nx == 9'd1 && w_line_nx == L_VBL)      w_vblank_nx = 1'b1;
    else if (w_dot_nx == 9'd1 && w_line_nx == L_PRE) w_vblank_nx = 1'b0;
  end

  nes_pattern_gen #(
    .P_VIS_W (VIS_W),
    .P_VIS_H (VIS_H)
  ) u_pattern (
    .i_mode      (w_mode_nx),
    .i_color     (w_color_nx),
    .i_dot       (w_dot_nx),
    .i_line      (w_line_nx),
    .i_frame_cnt (w_fcnt_nx),
    .o_pixel     (w_pix_nx)
  );

  // Counters, frame latches and output registers all advance on the dot tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dot    <= 9'd0;
      r_line   <= L_PRE;
      r_skip   <= 1'b0;
      r_odd    <= 1'b0;
      r_fcnt   <= 8'd0;
      r_mode   <= nes_video_pkg::MODE_SOLID;
      r_color  <= 8'd0;
      r_pix    <= 8'd0;
      r_h      <= 1'b0;
      r_v      <= 1'b0;
      r_vblank <= 1'b0;
    end else if (w_tick) begin
      r_dot    <= w_dot_nx;
      r_line   <= w_line_nx;
      r_skip   <= w_skip_nx;
      r_fcnt   <= w_fcnt_nx;
      r_mode   <= w_mode_nx;
      r_color  <= w_color_nx;
      r_pix    <= w_pix_nx;
      r_h      <= (w_dot_nx == L_DOT_LAST) || w_skip_nx;
      r_v      <= w_frame_start;
      r_vblank <= w_vblank_nx;
      if (w_frame_start) r_odd <= ~r_odd;
    end
  end

  assign pixel_out = r_pix;
  assign pixel_ce  = r_ce;
  assign h         = r_h;
  assign v         = r_v;
  assign vblank    = r_vblank;
  assign dot       = r_dot;
  assign line      = r_line;
  assign frame_odd = r_odd;

endmodule

// File: tb/tb_nes_video_source.sv
// tb/tb_nes_video_source.sv - directed self-checking bench for nes_video_source
module tb_nes_video_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Full NTSC-size instance, DIV=4
  logic       f_rst_n = 1'b0, f_en = 1'b1, f_ren = 1'b0;
  logic [1:0] f_mode = 2'd0;
  logic [7:0] f_col = 8'h2A;
  logic [7:0] f_pix;
  logic       f_ce, f_h, f_v, f_vb, f_odd;
  logic [8:0] f_dot, f_line;

  nes_video_source u_full (
    .clk(clk), .rst_n(f_rst_n), .enable(f_en), .render_en(f_ren),
    .mode(f_mode), .solid_color(f_col), .pixel_out(f_pix), .pixel_ce(f_ce),
    .h(f_h), .v(f_v), .vblank(f_vb), .dot(f_dot), .line(f_line), .frame_odd(f_odd)
  );

  // Scaled instance for whole-frame checks: 24x14 raster, 16x10 visible,
  // pre-render line 13, skip dot 22, vblank line 11
  logic       s_rst_n = 1'b0, s_en = 1'b1, s_ren = 1'b1;
  logic [1:0] s_mode = 2'd0;
  logic [7:0] s_col = 8'h11;
  logic [7:0] s_pix;
  logic       s_ce, s_h, s_v, s_vb, s_odd;
  logic [8:0] s_dot, s_line;

  nes_video_source #(.DIV(2), .DOTS(24), .LINES(14), .VIS_W(16), .VIS_H(10)) u_small (
    .clk(clk), .rst_n(s_rst_n), .enable(s_en), .render_en(s_ren),
    .mode(s_mode), .solid_color(s_col), .pixel_out(s_pix), .pixel_ce(s_ce),
    .h(s_h), .v(s_v), .vblank(s_vb), .dot(s_dot), .line(s_line), .frame_odd(s_odd)
  );

  typedef struct {
    logic [1:0] mode;
    logic [7:0] col;
    int         d;
    int         l;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[21];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic f_wait_pos(input int d, input int l);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(f_ce && f_dot == 9'(d) && f_line == 9'(l)) && n < 20000);
    if (n >= 20000) check($sformatf("timeout full pos %0d,%0d", d, l), 0, 1);
  endtask

  task automatic s_wait_pos(input int d, input int l);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(s_ce && s_dot == 9'(d) && s_line == 9'(l)) && n < 4000);
    if (n >= 4000) check($sformatf("timeout small pos %0d,%0d", d, l), 0, 1);
  endtask

  task automatic s_wait_v();
    int n = 0;
    do begin @(negedge clk); n++; end while (!(s_ce && s_v) && n < 4000);
    if (n >= 4000) check("timeout small v", 0, 1);
  endtask

  // Ticks from the current v tick up to and including the next v tick
  task automatic s_frame(output int ticks);
    int n = 0;
    ticks = 0;
    do begin @(negedge clk); n++; if (s_ce) ticks++; end while (!(s_ce && s_v) && n < 4000);
    if (n >= 4000) check("timeout small frame", 0, 1);
  endtask

  initial begin
    int n, t, cur_mode, hold_bad, rise_d, rise_l, fall_d, fall_l;
    logic [7:0] cur_col;
    bit frozen, prev;

    vt[0]  = '{2'd0, 8'h2A,   0, 0, 8'h2A};
    vt[1]  = '{2'd0, 8'h2A, 255, 0, 8'h2A};
    vt[2]  = '{2'd0, 8'h2A, 256, 0, 8'h00};
    vt[3]  = '{2'd0, 8'h2A, 100, 1, 8'h2A};
    vt[4]  = '{2'd0, 8'h2A, 340, 1, 8'h00};
    vt[5]  = '{2'd1, 8'h2A,   0, 0, 8'h00};
    vt[6]  = '{2'd1, 8'h2A,  31, 0, 8'h00};
    vt[7]  = '{2'd1, 8'h2A,  32, 0, 8'h01};
    vt[8]  = '{2'd1, 8'h2A, 255, 0, 8'h07};
    vt[9]  = '{2'd1, 8'h2A, 256, 0, 8'h00};
    vt[10] = '{2'd1, 8'h2A, 160, 1, 8'h05};
    vt[11] = '{2'd2, 8'h55,   0, 0, 8'h00};
    vt[12] = '{2'd2, 8'h55,   8, 0, 8'h55};
    vt[13] = '{2'd2, 8'h55,  16, 0, 8'h00};
    vt[14] = '{2'd2, 8'h55,   8, 1, 8'h55};
    vt[15] = '{2'd3, 8'h00,  10, 0, 8'h0B};
    vt[16] = '{2'd3, 8'h00, 254, 0, 8'hFF};
    vt[17] = '{2'd3, 8'h00, 255, 0, 8'h00};
    vt[18] = '{2'd3, 8'h00, 256, 0, 8'h00};
    vt[19] = '{2'd3, 8'h00,   1, 1, 8'h02};
    vt[20] = '{2'd3, 8'h00, 300, 1, 8'h00};

    // Reset state of the full instance
    #23;
    check("rst pixel", f_pix, 0);
    check("rst dot", f_dot, 0);
    check("rst line", f_line, 261);
    check("rst h/v/vb/odd/ce", {f_h, f_v, f_vb, f_odd, f_ce}, 0);

    // First v after release, then h period and position
    @(negedge clk);
    f_rst_n = 1'b1;
    s_rst_n = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!f_v && n < 3000);
    check("first v clks", n, 1364);
    check("first v line", f_line, 0);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!f_h && n < 3000);
    check("h dot", f_dot, 340);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (f_h && n < 3000);
    do begin @(posedge clk); #1; n++; end while (!f_h && n < 3000);
    check("h period clks", n, 1364);

    // Pixel table on the full instance; each mode group starts from reset
    cur_mode = -1;
    cur_col  = 8'h00;
    for (int i = 0; i < 21; i++) begin
      if (int'(vt[i].mode) != cur_mode || vt[i].col != cur_col) begin
        cur_mode = int'(vt[i].mode);
        cur_col  = vt[i].col;
        @(negedge clk);
        f_mode  = vt[i].mode;
        f_col   = vt[i].col;
        f_rst_n = 1'b0;
        @(negedge clk);
        f_rst_n = 1'b1;
      end
      f_wait_pos(vt[i].d, vt[i].l);
      check($sformatf("vec%0d pixel(%0d,%0d)", i, vt[i].d, vt[i].l), f_pix, vt[i].exp);
    end

    // Asynchronous reset in the middle of a line
    f_wait_pos(50, 2);
    #2 f_rst_n = 1'b0;
    #1;
    check("midrst full line", f_line, 261);
    check("midrst full dot", f_dot, 0);
    check("midrst full pixel", f_pix, 0);
    f_rst_n = 1'b1;

    // Odd-frame skip with render_en high, parity toggling at each v
    @(negedge clk);
    s_rst_n = 1'b0;
    @(negedge clk);
    s_rst_n = 1'b1;
    s_wait_v();
    check("odd after v1", s_odd, 1);
    s_frame(t);
    check("frame1 ticks (odd)", t, 335);
    check("odd after v2", s_odd, 0);
    s_frame(t);
    check("frame2 ticks (even)", t, 336);
    check("odd after v3", s_odd, 1);
    s_frame(t);
    check("frame3 ticks (odd)", t, 335);

    // render_en low: no skip on either parity
    s_ren = 1'b0;
    s_frame(t);
    check("ren0 even frame", t, 336);
    s_frame(t);
    check("ren0 odd frame", t, 336);

    // Scroll mode and a mid-frame mode change
    @(negedge clk);
    s_mode  = 2'd3;
    s_rst_n = 1'b0;
    @(negedge clk);
    s_rst_n = 1'b1;
    s_wait_v();
    s_wait_pos(10, 5);
    check("scroll frame1", s_pix, 11);
    s_wait_v();
    s_wait_pos(10, 5);
    check("scroll frame2", s_pix, 12);
    s_wait_pos(0, 7);
    s_mode = 2'd0;
    s_col  = 8'h3C;
    s_wait_pos(12, 8);
    check("mode change hidden", s_pix, 14);
    s_wait_v();
    s_wait_pos(10, 5);
    check("mode change next frame", s_pix, 8'h3C);

    // Enable held low for 1000 clks in the middle of line 5
    s_wait_v();
    t = 0; n = 0; frozen = 1'b0; hold_bad = 0;
    do begin
      @(negedge clk);
      n++;
      if (s_ce) t++;
      if (!frozen && s_ce && s_dot == 9'd7 && s_line == 9'd5) begin
        frozen = 1'b1;
        s_en   = 1'b0;
        for (int k = 0; k < 1000; k++) begin
          @(negedge clk);
          if (s_ce || s_dot != 9'd7 || s_line != 9'd5 || s_pix != 8'h3C) hold_bad++;
        end
        s_en = 1'b1;
      end
    end while (!(s_ce && s_v) && n < 5000);
    check("freeze reached", frozen, 1);
    check("freeze hold violations", hold_bad, 0);
    check("frame ticks with freeze", t, 336);

    // Reset during vblank, then one pre-render line before v and vblank window
    s_wait_pos(3, 12);
    check("vblank before rst", s_vb, 1);
    #2 s_rst_n = 1'b0;
    #1;
    check("midrst small line", s_line, 13);
    check("midrst small dot", s_dot, 0);
    check("midrst small outs", {s_pix, s_h, s_v, s_vb, s_ce}, 0);
    @(negedge clk);
    s_rst_n = 1'b1;
    t = 0; n = 0;
    do begin @(negedge clk); n++; if (s_ce) t++; end while (!(s_ce && s_v) && n < 4000);
    check("ticks to first v after rst", t, 24);
    rise_d = -1; rise_l = -1; fall_d = -1; fall_l = -1;
    prev = s_vb; n = 0;
    do begin
      @(negedge clk);
      n++;
      if (s_ce) begin
        if (s_vb && !prev) begin rise_d = int'(s_dot); rise_l = int'(s_line); end
        if (!s_vb && prev) begin fall_d = int'(s_dot); fall_l = int'(s_line); end
        prev = s_vb;
      end
    end while (fall_l < 0 && n < 4000);
    check("vblank rise line", rise_l, 11);
    check("vblank rise dot", rise_d, 1);
    check("vblank fall line", fall_l, 13);
    check("vblank fall dot", fall_d, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
